// File: rtl/dn_port_arbiter.sv
// Shared memory port arbiter: ROM download writes pass through when idle; the hiscore
// engine gets the port only after the CPU has been paused and the settle delay has elapsed.
module dn_port_arbiter #(
    parameter int PAUSEPAD = 2,
    parameter int WAIT_MAX = 4095
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        rom_busy,
    input  logic        rom_wr,
    input  logic [15:0] rom_addr,
    input  logic [7:0]  rom_data,
    input  logic        nv_req,
    input  logic        nv_stb,
    input  logic        nv_we,
    input  logic [9:0]  nv_addr,
    input  logic [7:0]  nv_din,
    output logic        nv_gnt,
    output logic        nv_ack,
    output logic [7:0]  nv_dout,
    output logic        nv_err,
    output logic        pause_req,
    input  logic        paused,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_we,
    output logic        mem_nv_we,
    output logic        mem_nv_sel,
    input  logic [7:0]  mem_dout
);

    // state        | meaning
    // S_IDLE       | ROM writes pass through; waiting for nv_req with no ROM download
    // S_PAUSE_WAIT | pause_req raised, waiting for paused (down-counter timeout)
    // S_PAD        | CPU halted, counting settle cycles
    // S_GRANT      | hiscore engine owns the port
    // S_RELEASE    | ownership and pause dropped, back to idle next cycle
    typedef enum logic [2:0] {
        S_IDLE,
        S_PAUSE_WAIT,
        S_PAD,
        S_GRANT,
        S_RELEASE
    } state_t;

    localparam int PAD_W  = (PAUSEPAD > 1) ? $clog2(PAUSEPAD) : 1;
    localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [PAD_W-1:0]  pad_cnt;
    logic              acc_busy;
    logic              acc_stage;
    logic              acc_we;
    logic              accept;

    assign accept = nv_gnt && nv_stb && !acc_busy;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            pad_cnt    <= '0;
            acc_busy   <= 1'b0;
            acc_stage  <= 1'b0;
            acc_we     <= 1'b0;
            nv_gnt     <= 1'b0;
            nv_ack     <= 1'b0;
            nv_dout    <= 8'h00;
            nv_err     <= 1'b0;
            pause_req  <= 1'b0;
            mem_addr   <= 16'h0000;
            mem_din    <= 8'h00;
            mem_we     <= 1'b0;
            mem_nv_we  <= 1'b0;
            mem_nv_sel <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            mem_nv_we <= 1'b0;
            nv_ack    <= 1'b0;
            nv_err    <= 1'b0;

            // Access pipeline: address out, memory responds, then ack with captured data.
            if (accept) begin
                mem_addr  <= {6'b0, nv_addr};
                mem_din   <= nv_din;
                mem_nv_we <= nv_we;
                acc_we    <= nv_we;
                acc_busy  <= 1'b1;
                acc_stage <= 1'b0;
            end else if (acc_busy) begin
                if (!acc_stage) begin
                    acc_stage <= 1'b1;
                end else begin
                    acc_busy  <= 1'b0;
                    acc_stage <= 1'b0;
                    nv_ack    <= 1'b1;
                    if (!acc_we) nv_dout <= mem_dout;
                end
            end

            case (state)
                S_IDLE: begin
                    if (rom_wr) begin
                        mem_addr   <= rom_addr;
                        mem_din    <= rom_data;
                        mem_we     <= 1'b1;
                        mem_nv_sel <= 1'b0;
                    end
                    if (nv_req && !rom_busy) begin
                        state     <= S_PAUSE_WAIT;
                        pause_req <= 1'b1;
                        wait_cnt  <= WAIT_W'(WAIT_MAX - 1);
                    end
                end
                S_PAUSE_WAIT: begin
                    if (!nv_req) begin
                        state     <= S_RELEASE;
                        pause_req <= 1'b0;
                    end else if (paused) begin
                        if (PAUSEPAD == 0) begin
                            state      <= S_GRANT;
                            nv_gnt     <= 1'b1;
                            mem_nv_sel <= 1'b1;
                        end else begin
                            state   <= S_PAD;
                            pad_cnt <= PAD_W'(PAUSEPAD - 1);
                        end
                    end else if (wait_cnt == '0) begin
                        state     <= S_IDLE;
                        pause_req <= 1'b0;
                        nv_err    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_PAD: begin
                    if (!nv_req) begin
                        state     <= S_RELEASE;
                        pause_req <= 1'b0;
                    end else if (pad_cnt == '0) begin
                        state      <= S_GRANT;
                        nv_gnt     <= 1'b1;
                        mem_nv_sel <= 1'b1;
                    end else begin
                        pad_cnt <= pad_cnt - 1'b1;
                    end
                end
                S_GRANT: begin
                    // Hold ownership until any in-flight access has been acknowledged.
                    if (!nv_req && !acc_busy && !accept) begin
                        state      <= S_RELEASE;
                        pause_req  <= 1'b0;
                        nv_gnt     <= 1'b0;
                        mem_nv_sel <= 1'b0;
                    end
                end
                S_RELEASE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dn_port_arbiter.sv
// Directed bench for dn_port_arbiter with a small synchronous RAM on the shared port.
module tb_dn_port_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        rom_busy, rom_wr;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        nv_req, nv_stb, nv_we;
    logic [9:0]  nv_addr;
    logic [7:0]  nv_din;
    logic        nv_gnt, nv_ack, nv_err, pause_req, paused;
    logic [7:0]  nv_dout;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_we, mem_nv_we, mem_nv_sel;
    logic [7:0]  mem_dout;

    logic [7:0]  nv_ram [0:1023];

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (mem_nv_we) nv_ram[mem_addr[9:0]] <= mem_din;
        mem_dout <= nv_ram[mem_addr[9:0]];
    end

    dn_port_arbiter #(.PAUSEPAD(2), .WAIT_MAX(16)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .rom_busy(rom_busy), .rom_wr(rom_wr), .rom_addr(rom_addr), .rom_data(rom_data),
        .nv_req(nv_req), .nv_stb(nv_stb), .nv_we(nv_we), .nv_addr(nv_addr), .nv_din(nv_din),
        .nv_gnt(nv_gnt), .nv_ack(nv_ack), .nv_dout(nv_dout), .nv_err(nv_err),
        .pause_req(pause_req), .paused(paused),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .mem_nv_we(mem_nv_we), .mem_nv_sel(mem_nv_sel), .mem_dout(mem_dout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) nv_ram[i] = 8'h00;
        reset = 1'b1; rom_busy = 1'b0; rom_wr = 1'b0; rom_addr = '0; rom_data = '0;
        nv_req = 1'b0; nv_stb = 1'b0; nv_we = 1'b0; nv_addr = '0; nv_din = '0; paused = 1'b0;
        tick(); tick();
        check("rst_mem_we", mem_we, 0);
        check("rst_pause_req", pause_req, 0);
        check("rst_nv_gnt", nv_gnt, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_nv_dout", nv_dout, 0);
        reset = 1'b0;
        tick();

        // ROM write during download; nv_req must be ignored
        rom_busy = 1'b1; rom_wr = 1'b1; rom_addr = 16'h1234; rom_data = 8'hA5; nv_req = 1'b1;
        tick();
        check("rom_mem_we", mem_we, 1);
        check("rom_mem_addr", mem_addr, 16'h1234);
        check("rom_mem_din", mem_din, 8'hA5);
        check("rom_nv_sel", mem_nv_sel, 0);
        check("rom_busy_pause", pause_req, 0);
        rom_wr = 1'b0;
        tick();
        check("rom_we_pulse", mem_we, 0);
        check("rom_busy_pause2", pause_req, 0);
        nv_req = 1'b0; rom_busy = 1'b0;
        tick();

        // nv_req together with rom_wr in IDLE, then pause handshake and settle pad
        nv_req = 1'b1; rom_wr = 1'b1; rom_addr = 16'h0042; rom_data = 8'h77;
        tick();
        check("both_mem_we", mem_we, 1);
        check("both_mem_addr", mem_addr, 16'h0042);
        check("both_pause_req", pause_req, 1);
        rom_wr = 1'b0;
        tick(); tick();
        check("pw_pause_held", pause_req, 1);
        check("pw_no_gnt", nv_gnt, 0);
        paused = 1'b1;
        tick();
        check("pad0_no_gnt", nv_gnt, 0);
        tick();
        check("pad1_no_gnt", nv_gnt, 0);
        check("pad1_pause", pause_req, 1);
        tick();
        check("grant_gnt", nv_gnt, 1);
        check("grant_sel", mem_nv_sel, 1);
        check("grant_pause", pause_req, 1);

        // ROM activity during GRANT is dropped and does not preempt
        rom_busy = 1'b1; rom_wr = 1'b1; rom_addr = 16'hBEEF;
        tick();
        check("grant_rom_drop", mem_we, 0);
        check("grant_no_preempt", nv_gnt, 1);
        rom_busy = 1'b0; rom_wr = 1'b0;

        // Write 0x3C to 0x005, strobe held while outstanding
        nv_stb = 1'b1; nv_we = 1'b1; nv_addr = 10'h005; nv_din = 8'h3C;
        tick();
        check("wr_nv_we", mem_nv_we, 1);
        check("wr_addr", mem_addr, 16'h0005);
        check("wr_din", mem_din, 8'h3C);
        check("wr_ack_early", nv_ack, 0);
        nv_addr = 10'h007; nv_din = 8'hEE;
        tick();
        check("wr_nv_we_pulse", mem_nv_we, 0);
        check("wr_outst_addr", mem_addr, 16'h0005);
        check("wr_ack_early2", nv_ack, 0);
        nv_stb = 1'b0;
        tick();
        check("wr_ack", nv_ack, 1);
        check("wr_dout_hold", nv_dout, 8'h00);
        tick();
        check("wr_ack_once", nv_ack, 0);
        check("wr_no_second", mem_nv_we, 0);

        // Read back 0x005
        nv_stb = 1'b1; nv_we = 1'b0; nv_addr = 10'h005;
        tick();
        check("rd_nv_we", mem_nv_we, 0);
        check("rd_addr", mem_addr, 16'h0005);
        nv_stb = 1'b0;
        tick();
        check("rd_ack_early", nv_ack, 0);
        tick();
        check("rd_ack", nv_ack, 1);
        check("rd_dout", nv_dout, 8'h3C);

        // nv_req drops one cycle after a read accept
        nv_stb = 1'b1; nv_addr = 10'h005;
        tick();
        nv_stb = 1'b0; nv_req = 1'b0;
        tick();
        check("drop_gnt_held", nv_gnt, 1);
        tick();
        check("drop_ack", nv_ack, 1);
        check("drop_dout", nv_dout, 8'h3C);
        tick();
        check("drop_gnt_fall", nv_gnt, 0);
        check("drop_pause_fall", pause_req, 0);
        check("drop_sel_fall", mem_nv_sel, 0);
        paused = 1'b0;
        tick();

        // Pause never arrives: timeout after 16 cycles
        nv_req = 1'b1;
        tick();
        check("to_pause_req", pause_req, 1);
        for (int i = 0; i < 15; i++) tick();
        check("to_err_early", nv_err, 0);
        check("to_pause_early", pause_req, 1);
        tick();
        check("to_err", nv_err, 1);
        check("to_pause_drop", pause_req, 0);
        check("to_gnt", nv_gnt, 0);
        nv_req = 1'b0;
        tick();
        check("to_err_once", nv_err, 0);
        check("to_idle_pause", pause_req, 0);

        // Reset in the middle of a read
        nv_req = 1'b1; paused = 1'b1;
        tick(); tick(); tick(); tick();
        check("mid_gnt", nv_gnt, 1);
        nv_stb = 1'b1; nv_we = 1'b0; nv_addr = 10'h005;
        tick();
        nv_stb = 1'b0; reset = 1'b1;
        tick();
        check("mid_rst_gnt", nv_gnt, 0);
        check("mid_rst_pause", pause_req, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_sel", mem_nv_sel, 0);
        check("mid_rst_ack", nv_ack, 0);
        reset = 1'b0; paused = 1'b0;
        tick();
        check("mid_no_ack", nv_ack, 0);
        check("mid_restart_pause", pause_req, 1);
        check("mid_restart_gnt", nv_gnt, 0);
        nv_req = 1'b0;
        tick();
        check("mid_release_pause", pause_req, 0);
        tick();
        check("mid_idle_gnt", nv_gnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dn_port_arbiter.md
DN_PORT_ARBITER -- requirements
Module: dn_port_arbiter

Interface
REQ-001 Parameter PAUSEPAD, default 2: settle cycles between observed CPU pause and first grant.
REQ-002 Parameter WAIT_MAX, default 4095: maximum cycles to wait for `paused` before abort.
REQ-003 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 rom_busy  in  1  ROM download in progress (level).
REQ-006 rom_wr  in  1  ROM byte write strobe.
REQ-007 rom_addr  in  16  ROM write address.
REQ-008 rom_data  in  8  ROM write data.
REQ-009 nv_req  in  1  hiscore engine requests ownership of the port (level).
REQ-010 nv_stb  in  1  hiscore access strobe, valid only while nv_gnt=1.
REQ-011 nv_we  in  1  1=write, 0=read; qualified by nv_stb.
REQ-012 nv_addr  in  10  hiscore RAM address.
REQ-013 nv_din  in  8  hiscore write data.
REQ-014 nv_gnt  out  1  port owned by hiscore engine.
REQ-015 nv_ack  out  1  one-cycle completion pulse per accepted access.
REQ-016 nv_dout  out  8  read data, valid while nv_ack=1.
REQ-017 nv_err  out  1  one-cycle pulse on pause timeout.
REQ-018 pause_req  out  1  CPU pause request to the pause block.
REQ-019 paused  in  1  CPU is halted.
REQ-020 mem_addr  out  16  shared port address (registered).
REQ-021 mem_din  out  8  shared port write data (registered).
REQ-022 mem_we  out  1  ROM write enable (registered).
REQ-023 mem_nv_we  out  1  NVRAM write enable (registered).
REQ-024 mem_nv_sel  out  1  NVRAM region selected (registered).
REQ-025 mem_dout  in  8  shared port read data, valid 1 cycle after address registered.

Function
REQ-026 States: IDLE, PAUSE_WAIT, PAD, GRANT, RELEASE.
REQ-027 IDLE: rom_wr passes through: next cycle mem_addr=rom_addr, mem_din=rom_data, mem_we=1, mem_nv_sel=0.
REQ-028 IDLE -> PAUSE_WAIT when nv_req=1 and rom_busy=0; pause_req=1 from the next cycle.
REQ-029 PAUSE_WAIT -> PAD on paused=1; PAD counts PAUSEPAD cycles then -> GRANT; PAUSEPAD=0 goes directly to GRANT.
REQ-030 PAUSE_WAIT wait counter: on WAIT_MAX cycles without paused -> IDLE, pause_req=0, nv_err pulses once.
REQ-031 nv_req=0 in PAUSE_WAIT, PAD or GRANT (no access outstanding) -> RELEASE; RELEASE drops pause_req, nv_gnt, mem_nv_sel, then -> IDLE next cycle.
REQ-032 GRANT: nv_gnt=1, pause_req=1, mem_nv_sel=1.
REQ-033 Access accepted when nv_stb=1, nv_gnt=1, none outstanding; next cycle mem_addr={6'b0,nv_addr}, mem_din=nv_din, mem_nv_we=nv_we.
REQ-034 mem_nv_we is a single-cycle pulse per accepted write.
REQ-035 nv_ack pulses exactly 2 cycles after acceptance; read: nv_dout=mem_dout sampled 1 cycle after address; write: nv_dout holds previous value.
REQ-036 One access outstanding at most; nv_stb during outstanding access is ignored (no ack).
REQ-037 nv_req falling with access outstanding: complete the access (ack issued), then RELEASE.
REQ-038 rom_wr outside IDLE is dropped; rom_busy rising in GRANT does not preempt.
REQ-039 nv_req and rom_wr same cycle in IDLE: ROM write issued, transition to PAUSE_WAIT also taken.

Reset
REQ-040 reset=1 forces IDLE, clears counters and outstanding flag; all outputs 0 on the next edge, including mid-access (pending nv_ack suppressed).
REQ-041 reset overrides every other input in the same cycle.

Verification
REQ-042 rom_busy=1, rom_wr with addr 0x1234, data 0xA5 -> next cycle mem_we=1, mem_addr=0x1234, mem_din=0xA5; nv_req ignored while rom_busy=1.
REQ-043 nv_req=1, paused rises 3 cycles later, PAUSEPAD=2 -> nv_gnt=1 exactly 2 cycles after paused seen; pause_req held throughout.
REQ-044 In GRANT: write 0x3C to 0x005, then read 0x005 with model returning 0x3C -> mem_nv_we single pulse, nv_ack 2 cycles after each accept, nv_dout=0x3C.
REQ-045 nv_req=1, paused never asserted, WAIT_MAX=16 -> after 16 cycles nv_err pulses once, pause_req=0, state IDLE.
REQ-046 Read accepted, reset asserted next cycle -> no nv_ack, all outputs 0 next edge; nv_req still high -> new PAUSE_WAIT sequence after reset release.
REQ-047 nv_req dropped one cycle after read accept -> nv_ack still issued, then pause_req and nv_gnt fall within 2 cycles.
